// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the iterative divider.
// Contents: divider op codes, divider FSM state encoding, iteration count,
// special-case result constants and a conditional two's-complement helper.
package cpu_pkg;

  localparam int unsigned DIV_XLEN  = 32;
  localparam int unsigned DIV_ITERS = 32;
  localparam int unsigned DIV_CNT_W = $clog2(DIV_ITERS);

  localparam logic [DIV_XLEN-1:0] DIV_ALL_ONES = 32'hFFFF_FFFF;
  localparam logic [DIV_XLEN-1:0] DIV_INT_MIN  = 32'h8000_0000;

  // funct3[1:0] of the RV32M divide group
  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_CALC   = 2'b01,
    S_FINISH = 2'b10
  } div_state_e;

  // Two's-complement negate when en is set, pass-through otherwise
  function automatic logic [DIV_XLEN-1:0] cond_neg(input logic [DIV_XLEN-1:0] x,
                                                    input logic                en);
    return en ? (~x + DIV_XLEN'(1)) : x;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration (purely combinational).
// Ports:
//   rem_i     - partial remainder entering this iteration
//   dvd_msb_i - dividend bit shifted into the remainder
//   dvs_i     - divisor magnitude
//   rem_o     - partial remainder leaving this iteration
//   q_bit_o   - quotient bit produced by this iteration
module div_step
  import cpu_pkg::*;
#(
  parameter int unsigned W = DIV_XLEN
) (
  input  logic [W-1:0] rem_i,
  input  logic         dvd_msb_i,
  input  logic [W-1:0] dvs_i,
  output logic [W-1:0] rem_o,
  output logic         q_bit_o
);

  logic [W:0] trial;
  logic [W:0] diff;

  // rem_i < divisor, so the W+1 bit trial never overflows and diff[W]
  // is set exactly when the subtraction would go negative.
  always_comb begin
    trial   = {rem_i, dvd_msb_i};
    diff    = trial - {1'b0, dvs_i};
    q_bit_o = ~diff[W];
    rem_o   = q_bit_o ? diff[W-1:0] : trial[W-1:0];
  end

endmodule

// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU), 32 restoring iterations on
// operand magnitudes followed by a sign fix-up cycle.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   start, flush - request a division / abort the one in flight
//   op           - funct3[1:0]: DIV, DIVU, REM, REMU
//   rs1_data     - dividend, rs2_data - divisor, rd_in - destination tag
//   busy         - operation in flight (through the result_valid cycle)
//   result_valid - one-cycle pulse when result/rd_out are new
//   result       - quotient or remainder, rd_out - its tag
// Build option DIV_EARLY_OUT_EN: divide-by-zero, signed overflow and a zero
// dividend skip the iterations and complete with a latency of 1.
module div_unit
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN = DIV_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  div_state_e           state_q, state_d;
  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]      dq_q, dq_d;    // dividend shifting out, quotient shifting in
  logic [XLEN-1:0]      rem_q, rem_d;
  logic [XLEN-1:0]      dvs_q, dvs_d;
  logic                 q_neg_q, q_neg_d;
  logic                 r_neg_q, r_neg_d;
  logic                 rem_sel_q, rem_sel_d;
  logic                 dz_q, dz_d;
  logic                 ovf_q, ovf_d;
  logic [4:0]           rd_q, rd_d;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;
  logic [XLEN-1:0]      result_q, result_d;
  logic [4:0]           rd_out_q, rd_out_d;

  div_op_e              op_e;
  logic                 signed_op;
  logic [XLEN-1:0]      a_mag, b_mag;
  logic                 dz_c, ovf_c;
  logic [XLEN-1:0]      step_rem;
  logic                 step_q_bit;
  logic [XLEN-1:0]      q_res, r_res;

  // Operand decode: magnitudes and special-case detection at accept time
  always_comb begin
    op_e      = div_op_e'(op);
    signed_op = (op_e == OP_DIV) || (op_e == OP_REM);
    a_mag     = cond_neg(rs1_data, signed_op && rs1_data[XLEN-1]);
    b_mag     = cond_neg(rs2_data, signed_op && rs2_data[XLEN-1]);
    dz_c      = (rs2_data == '0);
    ovf_c     = signed_op && (rs1_data == DIV_INT_MIN) && (rs2_data == DIV_ALL_ONES);
  end

  div_step #(.W(XLEN)) u_step (
    .rem_i     (rem_q),
    .dvd_msb_i (dq_q[XLEN-1]),
    .dvs_i     (dvs_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_q_bit)
  );

  // Final result selection; special cases override the iterated values
  always_comb begin
    q_res = dz_q  ? DIV_ALL_ONES :
            ovf_q ? DIV_INT_MIN  : cond_neg(dq_q, q_neg_q);
    r_res = ovf_q ? '0 : cond_neg(rem_q, r_neg_q);
  end

  // Next-state and datapath
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dq_d      = dq_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    rem_sel_d = rem_sel_q;
    dz_d      = dz_q;
    ovf_d     = ovf_q;
    rd_d      = rd_q;
    busy_d    = 1'b0;
    valid_d   = 1'b0;
    result_d  = result_q;
    rd_out_d  = rd_out_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_CALC;
          busy_d    = 1'b1;
          cnt_d     = '0;
          dq_d      = a_mag;
          rem_d     = '0;
          dvs_d     = b_mag;
          q_neg_d   = signed_op && (rs1_data[XLEN-1] ^ rs2_data[XLEN-1]);
          r_neg_d   = signed_op && rs1_data[XLEN-1];
          rem_sel_d = op[1];
          dz_d      = dz_c;
          ovf_d     = ovf_c;
          rd_d      = rd_in;
`ifdef DIV_EARLY_OUT_EN
          // Remainder of x/0 is x itself; preload it since no iteration runs
          if (dz_c || ovf_c || (rs1_data == '0)) begin
            state_d = S_FINISH;
            rem_d   = dz_c ? a_mag : '0;
          end
`endif
        end
      end
      S_CALC: begin
        busy_d = 1'b1;
        dq_d   = {dq_q[XLEN-2:0], step_q_bit};
        rem_d  = step_rem;
        cnt_d  = cnt_q + DIV_CNT_W'(1);
        if (cnt_q == DIV_CNT_W'(DIV_ITERS - 1)) begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        busy_d   = 1'b1;
        valid_d  = 1'b1;
        result_d = rem_sel_q ? r_res : q_res;
        rd_out_d = rd_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Flush beats everything, including a same-cycle start
    if (flush) begin
      state_d  = S_IDLE;
      busy_d   = 1'b0;
      valid_d  = 1'b0;
      result_d = result_q;
      rd_out_d = rd_out_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      dq_q      <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      rem_sel_q <= 1'b0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
      rd_q      <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      result_q  <= '0;
      rd_out_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dq_q      <= dq_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      rem_sel_q <= rem_sel_d;
      dz_q      <= dz_d;
      ovf_q     <= ovf_d;
      rd_q      <= rd_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      result_q  <= result_d;
      rd_out_q  <= rd_out_d;
    end
  end

  assign busy         = busy_q;
  assign result_valid = valid_q;
  assign result       = result_q;
  assign rd_out       = rd_out_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: scoreboard of expected results pushed at
// stimulus time and popped when result_valid pulses.
module tb_div_unit;

  localparam int NORM_LAT = 33;
`ifdef DIV_EARLY_OUT_EN
  localparam int SPEC_LAT = 1;
`else
  localparam int SPEC_LAT = 33;
`endif

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic [4:0]  rd_in = '0;
  logic        busy;
  logic        result_valid;
  logic [31:0] result;
  logic [4:0]  rd_out;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] last_res = '0;

  div_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .flush        (flush),
    .op           (op),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .rd_in        (rd_in),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result),
    .rd_out       (rd_out)
  );

  always #5 clk = ~clk;

  // Reference: RISC-V M-extension semantics
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    logic        sgn;
    logic [31:0] q, r;
    sgn = (o == 2'b00) || (o == 2'b10);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0;
    end else if (sgn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b; r = a % b;
    end
    return o[1] ? r : q;
  endfunction

  // Called at posedge+1; start is sampled at the next edge (edge 0)
  task automatic drive_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
    start = 1'b1; op = o; rs1_data = a; rs2_data = b; rd_in = rd;
    @(posedge clk); #1;
    start = 1'b0; rs1_data = $urandom; rs2_data = $urandom; rd_in = 5'($urandom);
  endtask

  // Counts edges after edge 0 until result_valid is seen (bounded)
  task automatic wait_valid(output int lat, output bit got);
    lat = 0; got = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (result_valid) begin lat = i; got = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_cmp++; if (result_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b want=0", result_valid); end
    n_cmp++; if (result !== 32'd0) begin n_err++; $display("FAIL reset_result got=%h want=0", result); end
    n_cmp++; if (rd_out !== 5'd0) begin n_err++; $display("FAIL reset_rd got=%0d want=0", rd_out); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0 || result_valid !== 1'b0) begin
      n_err++; $display("FAIL post_reset_idle busy=%b valid=%b want 0/0", busy, result_valid);
    end
  endtask

  // Table of plan vectors plus random ops, each checked for value, tag, latency, pulse width, hold
  task automatic test_arith(input string name, input int n, input logic [1:0] ops[],
                            input logic [31:0] as[], input logic [31:0] bs[],
                            input logic [31:0] exps[], input int lat_exp[]);
    int   lat;
    bit   got;
    exp_t e;
    for (int i = 0; i < n; i++) begin
      sb_q.push_back('{res: exps[i], rd: 5'(i + 3)});
      drive_op(ops[i], as[i], bs[i], 5'(i + 3));
      wait_valid(lat, got);
      e = sb_q.pop_front();
      n_cmp++;
      if (!got) begin
        n_err++; $display("FAIL %s[%0d]_timeout got=no_valid want=valid", name, i);
        continue;
      end
      if (result !== e.res) begin
        n_err++; $display("FAIL %s[%0d]_result got=%h want=%h", name, i, result, e.res);
      end
      n_cmp++; if (rd_out !== e.rd) begin
        n_err++; $display("FAIL %s[%0d]_rd got=%0d want=%0d", name, i, rd_out, e.rd);
      end
      n_cmp++; if (lat !== lat_exp[i]) begin
        n_err++; $display("FAIL %s[%0d]_latency got=%0d want=%0d", name, i, lat, lat_exp[i]);
      end
      n_cmp++; if (busy !== 1'b1) begin
        n_err++; $display("FAIL %s[%0d]_busy_in_valid got=%b want=1", name, i, busy);
      end
      last_res = e.res;
      @(posedge clk); #1;
      n_cmp++; if (result_valid !== 1'b0 || busy !== 1'b0) begin
        n_err++; $display("FAIL %s[%0d]_pulse valid=%b busy=%b want 0/0", name, i, result_valid, busy);
      end
      n_cmp++; if (result !== e.res) begin
        n_err++; $display("FAIL %s[%0d]_hold got=%h want=%h", name, i, result, e.res);
      end
    end
  endtask

  task automatic test_back_to_back();
    int   lat;
    bit   got;
    exp_t e;
    sb_q.push_back('{res: 32'd5, rd: 5'd21});
    sb_q.push_back('{res: 32'hFFFF_FFFA, rd: 5'd22});
    drive_op(2'b01, 32'd35, 32'd7, 5'd21);
    wait_valid(lat, got);
    e = sb_q.pop_front();
    n_cmp++; if (!got || result !== e.res) begin
      n_err++; $display("FAIL b2b_first got=%h want=%h", result, e.res);
    end
    // Start during the result_valid cycle: accepted at the edge ending it
    drive_op(2'b00, 32'd36, 32'hFFFF_FFFA, 5'd22);
    n_cmp++; if (busy !== 1'b1) begin
      n_err++; $display("FAIL b2b_accept_busy got=%b want=1", busy);
    end
    wait_valid(lat, got);
    e = sb_q.pop_front();
    n_cmp++; if (!got || result !== e.res || rd_out !== e.rd) begin
      n_err++; $display("FAIL b2b_second got=%h/%0d want=%h/%0d", result, rd_out, e.res, e.rd);
    end
    n_cmp++; if (lat !== NORM_LAT) begin
      n_err++; $display("FAIL b2b_latency got=%0d want=%0d", lat, NORM_LAT);
    end
    last_res = e.res;
    @(posedge clk); #1;
  endtask

  task automatic test_start_while_busy();
    int   lat;
    bit   got;
    int   pulses;
    exp_t e;
    sb_q.push_back('{res: 32'd142, rd: 5'd11});
    drive_op(2'b01, 32'd1000, 32'd7, 5'd11);
    repeat (4) begin @(posedge clk); #1; end
    drive_op(2'b00, 32'd50, 32'd2, 5'd12);  // sampled at cycle 5, must be ignored
    wait_valid(lat, got);
    e = sb_q.pop_front();
    n_cmp++; if (!got || result !== e.res || rd_out !== e.rd) begin
      n_err++; $display("FAIL busy_start_result got=%h/%0d want=%h/%0d", result, rd_out, e.res, e.rd);
    end
    n_cmp++; if (lat !== NORM_LAT - 5) begin
      n_err++; $display("FAIL busy_start_latency got=%0d want=%0d", lat, NORM_LAT - 5);
    end
    last_res = e.res;
    pulses = 0;
    repeat (40) begin @(posedge clk); #1; if (result_valid) pulses++; end
    n_cmp++; if (pulses !== 0 || busy !== 1'b0) begin
      n_err++; $display("FAIL busy_start_extra pulses=%0d busy=%b want 0/0", pulses, busy);
    end
  endtask

  task automatic test_flush();
    int pulses;
    drive_op(2'b00, 32'd999, 32'd3, 5'd14);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_busy got=%b want=0", busy); end
    n_cmp++; if (result !== last_res) begin
      n_err++; $display("FAIL flush_result got=%h want=%h", result, last_res);
    end
    pulses = 0;
    repeat (40) begin @(posedge clk); #1; if (result_valid) pulses++; end
    n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL flush_valid pulses=%0d want=0", pulses); end
    // start and flush together in IDLE: nothing accepted
    flush = 1'b1;
    drive_op(2'b01, 32'd77, 32'd7, 5'd15);
    flush = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_start_busy got=%b want=0", busy); end
    pulses = 0;
    repeat (40) begin @(posedge clk); #1; if (result_valid || busy) pulses++; end
    n_cmp++; if (pulses !== 0 || result !== last_res) begin
      n_err++; $display("FAIL flush_start_accept cycles=%0d result=%h want 0/%h", pulses, result, last_res);
    end
  endtask

  task automatic test_reset_mid();
    int   lat;
    bit   got;
    exp_t e;
    drive_op(2'b01, 32'd1000, 32'd3, 5'd17);
    repeat (10) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0 || result_valid !== 1'b0 || result !== 32'd0 || rd_out !== 5'd0) begin
      n_err++; $display("FAIL async_reset busy=%b valid=%b result=%h rd=%0d want all 0",
                        busy, result_valid, result, rd_out);
    end
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    sb_q.push_back('{res: 32'd14, rd: 5'd9});
    drive_op(2'b01, 32'd100, 32'd7, 5'd9);
    wait_valid(lat, got);
    e = sb_q.pop_front();
    n_cmp++; if (!got || result !== e.res || rd_out !== e.rd) begin
      n_err++; $display("FAIL after_reset_result got=%h/%0d want=%h/%0d", result, rd_out, e.res, e.rd);
    end
    n_cmp++; if (lat !== NORM_LAT) begin
      n_err++; $display("FAIL after_reset_latency got=%0d want=%0d", lat, NORM_LAT);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [1:0]  ops[];
    logic [31:0] as[], bs[], exps[];
    int          lats[];

    test_reset();

    // Plan vectors with hand-derived results
    ops  = '{2'b00, 2'b10, 2'b01, 2'b11};
    as   = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    bs   = '{32'h2, 32'h2, 32'h10, 32'h10};
    exps = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h0FFF_FFFF, 32'hF};
    lats = '{NORM_LAT, NORM_LAT, NORM_LAT, NORM_LAT};
    test_arith("arith", 4, ops, as, bs, exps, lats);

    // RISC-V special cases: x/0, signed overflow, zero dividend
    ops  = '{2'b00, 2'b11, 2'b00, 2'b10, 2'b10, 2'b01, 2'b00};
    as   = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFB, 32'd0, 32'd0};
    bs   = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd9, 32'hFFFF_FFF0};
    exps = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFB, 32'd0, 32'd0};
    lats = '{SPEC_LAT, SPEC_LAT, SPEC_LAT, SPEC_LAT, SPEC_LAT, SPEC_LAT, SPEC_LAT};
    test_arith("special", 7, ops, as, bs, exps, lats);

    // Random operands against the reference model
    ops = new[8]; as = new[8]; bs = new[8]; exps = new[8]; lats = new[8];
    for (int i = 0; i < 8; i++) begin
      ops[i] = 2'(i);
      as[i]  = $urandom;
      bs[i]  = (i < 4) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (i == 6) bs[i] = 32'hFFFF_FFF1;
      exps[i] = model(ops[i], as[i], bs[i]);
      lats[i] = NORM_LAT;
    end
    test_arith("random", 8, ops, as, bs, exps, lats);

    test_back_to_back();
    test_start_while_busy();
    test_flush();
    test_reset_mid();

    n_cmp++; if (sb_q.size() !== 0) begin
      n_err++; $display("FAIL scoreboard_drain left=%0d want=0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
